// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Owns the fetch PC and keeps at most one instruction-memory request in flight.
// Each fetched instruction is parked in a single output slot until decode takes it.
// Next-PC priority: redirect first, then BTB prediction, then sequential PC+4.
// Optional feature macro: FETCH_BTB_EN enables the BTB-predicted next PC.
// Without FETCH_BTB_EN, the BTB inputs are ignored, lookup_pc is 0, and every
// prediction is PC+4.
module fetch_sequencer #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                btb_hit,
    input  logic [PC_WIDTH-1:0] btb_pc,
    output logic [PC_WIDTH-1:0] lookup_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                out_valid,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [31:0]         out_insn,
    output logic                out_pred_taken,
    output logic [PC_WIDTH-1:0] out_pred_pc
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } stateType;

    stateType            state;
    stateType            stateNext;

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pcPlus4;
    logic [PC_WIDTH-1:0] redirectAligned;
    logic                predTaken;
    logic [PC_WIDTH-1:0] predPc;

    // Entry for the single outstanding request, consumed when its response lands.
    logic [PC_WIDTH-1:0] pendPc;
    logic                pendTaken;
    logic [PC_WIDTH-1:0] pendPredPc;

    logic                slotFree;
    logic                reqFire;
    logic                loadSlot;
    logic                unusedBits;

    assign pcPlus4         = pc + PC_WIDTH'(4);
    assign redirectAligned = {redirect_pc[PC_WIDTH-1:2], 2'b00};

    // The slot can take a new instruction if it is empty or is being drained this cycle.
    assign slotFree  = !out_valid || !stall;
    assign reqFire   = imem_req && imem_gnt;
    // A redirect in the same cycle makes the arriving response stale.
    assign loadSlot  = (state == WAIT) && imem_rvalid && !redirect;
    assign imem_addr = pc;

`ifdef FETCH_BTB_EN
    assign lookup_pc  = pc;
    assign predTaken  = btb_hit;
    assign predPc     = btb_hit ? {btb_pc[PC_WIDTH-1:2], 2'b00} : pcPlus4;
    assign unusedBits = ^{redirect_pc[1:0], btb_pc[1:0]};
`else
    assign lookup_pc  = '0;
    assign predTaken  = 1'b0;
    assign predPc     = pcPlus4;
    assign unusedBits = ^{redirect_pc[1:0], btb_hit, btb_pc};
`endif

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= REQ;
        end else begin
            state <= stateNext;
        end
    end

    // Next state. A redirect only alters the path when a response is still owed.
    always_comb begin
        stateNext = state;
        case (state)
            REQ: begin
                if (reqFire) begin
                    stateNext = redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    stateNext = REQ;
                end else if (redirect) begin
                    stateNext = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    stateNext = REQ;
                end
            end
            default: stateNext = REQ;
        endcase
    end

    // Request only from REQ, only when the slot can accept, and never while in reset.
    always_comb begin
        imem_req = 1'b0;
        if (rst && (state == REQ)) begin
            imem_req = slotFree;
        end
    end

    // Fetch PC. A redirect overrides the prediction taken by an accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirectAligned;
        end else if (reqFire) begin
            pc <= predPc;
        end
    end

    // Capture the metadata of the request that memory just accepted.
    always_ff @(posedge clk) begin
        if (reqFire) begin
            pendPc     <= pc;
            pendTaken  <= predTaken;
            pendPredPc <= predPc;
        end
    end

    // Output slot. A redirect flushes it; a response reloads it; decode drains it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_insn       <= '0;
            out_pred_taken <= 1'b0;
            out_pred_pc    <= '0;
        end else if (redirect) begin
            out_valid <= 1'b0;
        end else if (loadSlot) begin
            out_valid      <= 1'b1;
            out_pc         <= pendPc;
            out_insn       <= imem_rdata;
            out_pred_taken <= pendTaken;
            out_pred_pc    <= pendPredPc;
        end else if (out_valid && !stall) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences the fetch stage. Owns the fetch PC register, issues one instruction-memory request at a time, and selects the next PC from three sources: redirect, BTB prediction, or sequential PC+4. It discards responses that a redirect has made stale, and holds one fetched instruction in an output slot until decode accepts it. It sits between the BTB and branch-redirect logic on one side and the decode pipe register on the other.

## Interface
Parameters:
- PC_WIDTH, 32, width of all PC/address signals
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- stall  in  1  decode not accepting; output slot holds while 1
- redirect  in  1  mispredict/exception redirect from execute
- redirect_pc  in  PC_WIDTH  redirect target
- btb_hit  in  1  BTB hit for lookup_pc (combinational, same cycle)
- btb_pc  in  PC_WIDTH  BTB predicted target
- lookup_pc  out  PC_WIDTH  current fetch PC, presented to the BTB
- imem_req  out  1  instruction-memory request
- imem_addr  out  PC_WIDTH  request address (= fetch PC)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid
- imem_rdata  in  32  response instruction
- out_valid  out  1  output slot holds an instruction
- out_pc  out  PC_WIDTH  PC of the held instruction
- out_insn  out  32  held instruction
- out_pred_taken  out  1  BTB predicted taken at fetch
- out_pred_pc  out  PC_WIDTH  predicted next PC (btb_pc or pc+4)

## Operation
- State machine states: REQ, WAIT, DROP. Reset state is REQ.
- The fetch PC always has bits [1:0] = 2'b00. Low bits of redirect_pc and btb_pc are ignored.
- The slot is "free" when out_valid=0, or when out_valid=1 and stall=0 (draining this cycle).
- **REQ**
  - imem_req = slot free.
  - On imem_req & imem_gnt: latch pending pc, pred_taken = btb_hit, and pred_pc = btb_hit ? btb_pc : pc+4.
  - Same edge: fetch PC <= pred_pc, and state -> WAIT.
- **WAIT**
  - imem_req = 0.
  - On imem_rvalid: load the slot (out_valid=1, out_pc, out_insn, out_pred_*) from the pending entry, then -> REQ.
  - The slot is always free at response time, because at most one request is outstanding.
- **Slot drain:** out_valid & !stall clears out_valid unless the slot is reloaded on the same edge.
- **redirect = 1 has highest priority, in any state:**
  - fetch PC <= redirect_pc, out_valid <= 0, and the pending entry is invalidated.
  - Next state:
    - REQ without gnt -> REQ.
    - REQ with gnt -> DROP.
    - WAIT with rvalid -> REQ; the response is discarded.
    - WAIT without rvalid -> DROP.
    - DROP with rvalid -> REQ; otherwise stay in DROP.
- **DROP**
  - imem_req = 0.
  - The next imem_rvalid is discarded, and the state -> REQ.
- PC+4 wraps modulo 2^PC_WIDTH.

## Timing
- Reset values:
  - pc = RESET_PC; state = REQ.
  - out_valid=0, out_pc=0, out_insn=0, out_pred_taken=0, out_pred_pc=0.
  - imem_req=1 from the first cycle after rst deasserts; it is 0 while in reset.
- imem_req and imem_addr are combinational from state, PC and slot status.
- imem_addr is stable while imem_req=1 and imem_gnt=0. The only exception is a redirect, which replaces the address on the next cycle.
- Latencies:
  - gnt at cycle N -> next imem_req at the cycle after rvalid.
  - rvalid at cycle R -> out_valid=1 at R+1.
  - Redirect at cycle N -> imem_req with redirect_pc at N+1, when not in DROP.
- Peak throughput: one instruction per 2 cycles with single-cycle memory.
- Asserting rst mid-request abandons the outstanding request. Memory responses arriving during reset are ignored.

## Configuration
- **FETCH_BTB_EN defined:** behaves as described above.
- **FETCH_BTB_EN undefined:**
  - btb_hit and btb_pc are ignored and lookup_pc is driven 0.
  - pred_taken is always 0 and pred_pc is always pc+4.

## Test plan
- Reset release, RESET_PC=0x100, gnt and rvalid one cycle apart, stall=0 -> out_pc = 0x100, 0x104, 0x108; imem_req=0 during rst=0.
- BTB hit at 0x104 with btb_pc=0x200 (FETCH_BTB_EN) -> out_pred_taken=1, out_pred_pc=0x200, next imem_addr=0x200. Same case without the macro -> 0x108.
- stall=1 for 5 cycles with out_valid=1 -> slot and out_insn unchanged, imem_req=0; after stall drops, the next request issues the same cycle.
- Redirect to 0x400 while in WAIT, with rvalid 2 cycles later -> that response never appears on out_valid; the next request has address 0x400.
- Redirect coincident with gnt in REQ -> DROP; one response discarded, then fetch from the redirect target. Redirect with redirect_pc=0x403 -> imem_addr=0x400.
- PC at 0xFFFF_FFFC sequential -> next imem_addr=0x0000_0000. Reset asserted mid-WAIT -> all outputs return to reset values asynchronously.
